// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive-side blocks.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package uart_pkg;

  // Width of one received character.
  localparam int UART_DATA_W = 8;

  // System clocks per bit for a 50 MHz clock at 115200 baud (50e6/115200 = 434.03).
  localparam int CLK_DIV_DEFAULT = 434;

  // Ceiling log2 for sizing counters from constants; returns at least 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-side and bus-side signals of the UART receive controller.
// Latency: n/a (wiring only).
// Backpressure: bus side pops with rd_en; receiver side is never stalled.
interface uart_rx_ctrl_if
  import uart_pkg::*;
#(
  parameter int FIFO_AW = 2
);

  // Receiver datapath side
  logic                   rx_bps_en;
  logic [UART_DATA_W-1:0] rx_data;
  logic                   rx_done;
  logic                   clk_uart;

  // Bus / peripheral wrapper side
  logic                   rd_en;
  logic [UART_DATA_W-1:0] rd_data;
  logic                   empty;
  logic                   full;
  logic [FIFO_AW:0]       level;
  logic                   overrun;
  logic                   clr_ovr;
  logic                   irq_en;
  logic                   irq;

  // Controller view
  modport slave (
    input  rx_bps_en, rx_data, rx_done, rd_en, clr_ovr, irq_en,
    output clk_uart, rd_data, empty, full, level, overrun, irq
  );

  // Driver view (receiver model plus bus master)
  modport master (
    output rx_bps_en, rx_data, rx_done, rd_en, clr_ovr, irq_en,
    input  clk_uart, rd_data, empty, full, level, overrun, irq
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO with pointer-difference level and push/pop arbitration.
// Latency: push visible at head next cycle; pop advances head next cycle.
// Backpressure: push when full is rejected (o_rej) unless a pop frees a slot in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic                   clk,
  input  logic                   RSTn,
  input  logic                   i_push,
  input  logic [UART_DATA_W-1:0] i_push_dat,
  input  logic                   i_pop_req,
  output logic [UART_DATA_W-1:0] o_rd_dat,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [AW:0]            o_level,
  output logic                   o_rej
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [UART_DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]            r_wr_ptr;
  logic [AW:0]            r_rd_ptr;

  logic [AW:0]            w_level;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push_ok;

  // Pointers carry one extra wrap bit, so their difference is the fill level directly.
  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (w_level == '0);
  assign w_full    = (w_level == FULL_LVL);

  // Pop is gated by empty; a push into a full FIFO is still taken when a pop frees the head slot.
  assign w_pop     = i_pop_req & ~w_empty;
  assign w_push_ok = i_push & (~w_full | w_pop);

  assign o_rej     = i_push & ~w_push_ok;
  assign o_level   = w_level;
  assign o_empty   = w_empty;
  assign o_full    = w_full;
  assign o_rd_dat  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; both may move in the same cycle.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud tick generation, end-of-frame capture into a FIFO, overrun and irq.
// Latency: first tick CLK_DIV/2 cycles after rx_bps_en rises; byte at FIFO head 1 cycle after rx_done rises; irq 1 cycle after cause.
// Backpressure: bus pops via rd_en; a frame arriving with the FIFO full is dropped and flagged as overrun.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int FIFO_AW = 2
) (
  input  logic           clk,
  input  logic           RSTn,
  uart_rx_ctrl_if.slave  bus
);

  localparam int                CNT_W    = clog2(CLK_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_MID  = CNT_W'(CLK_DIV / 2 - 1);

  logic [CNT_W-1:0]       r_div_cnt;
  logic                   r_clk_uart;
  logic                   r_rx_done_q;
  logic                   r_overrun;
  logic                   r_irq;

  logic                   w_push;
  logic                   w_rej;
  logic                   w_empty;
  logic                   w_full;
  logic [FIFO_AW:0]       w_level;
  logic [UART_DATA_W-1:0] w_rd_data;

  // Baud divider: free-runs only while the receiver is busy; the tick lands mid-bit.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_div_cnt  <= '0;
      r_clk_uart <= 1'b0;
    end else if (!bus.rx_bps_en) begin
      r_div_cnt  <= '0;
      r_clk_uart <= 1'b0;
    end else begin
      r_div_cnt  <= (r_div_cnt == CNT_LAST) ? '0 : r_div_cnt + 1'b1;
      r_clk_uart <= (r_div_cnt == CNT_MID);
    end
  end

  // Delayed copy of the end-of-frame level for rising-edge detection.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) r_rx_done_q <= 1'b0;
    else       r_rx_done_q <= bus.rx_done;
  end

  // rx_done may be held for several cycles; only its first cycle pushes a byte.
  assign w_push = bus.rx_done & ~r_rx_done_q;

  uart_rx_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk        (clk),
    .RSTn       (RSTn),
    .i_push     (w_push),
    .i_push_dat (bus.rx_data),
    .i_pop_req  (bus.rd_en),
    .o_rd_dat   (w_rd_data),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_level    (w_level),
    .o_rej      (w_rej)
  );

  // Sticky overrun; a lost byte in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn)             r_overrun <= 1'b0;
    else if (w_rej)        r_overrun <= 1'b1;
    else if (bus.clr_ovr)  r_overrun <= 1'b0;
  end

  // Interrupt while data is waiting or a byte was lost, masked by irq_en.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) r_irq <= 1'b0;
    else       r_irq <= bus.irq_en & (~w_empty | r_overrun);
  end

  assign bus.clk_uart = r_clk_uart;
  assign bus.rd_data  = w_rd_data;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.level    = w_level;
  assign bus.overrun  = r_overrun;
  assign bus.irq      = r_irq;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with CLK_DIV=8, FIFO_AW=2.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_ctrl;

  logic clk;
  logic RSTn;
  int   n_vec;
  int   n_err;

  uart_rx_ctrl_if #(.FIFO_AW(2)) bus ();

  uart_rx_ctrl #(
    .CLK_DIV (8),
    .FIFO_AW (2)
  ) dut (
    .clk  (clk),
    .RSTn (RSTn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame: rx_done high for one cycle, then low for one cycle.
  task automatic push_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    cyc(1);
    bus.rx_done = 1'b0;
    cyc(1);
  endtask

  // Check the head, then pop it.
  task automatic pop_chk(input string tag, input logic [7:0] b);
    chk(tag, 32'(bus.rd_data), 32'(b));
    bus.rd_en = 1'b1;
    cyc(1);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    RSTn          = 1'b0;
    bus.rx_bps_en = 1'b0;
    bus.rx_data   = 8'h00;
    bus.rx_done   = 1'b0;
    bus.rd_en     = 1'b0;
    bus.clr_ovr   = 1'b0;
    bus.irq_en    = 1'b0;

    // Reset state
    cyc(2);
    chk("rst_clk_uart", 32'(bus.clk_uart), 32'd0);
    chk("rst_empty",    32'(bus.empty),    32'd1);
    chk("rst_full",     32'(bus.full),     32'd0);
    chk("rst_level",    32'(bus.level),    32'd0);
    chk("rst_overrun",  32'(bus.overrun),  32'd0);
    chk("rst_irq",      32'(bus.irq),      32'd0);
    chk("rst_rd_data",  32'(bus.rd_data),  32'd0);
    RSTn = 1'b1;
    cyc(1);

    // Baud ticks at 4, 12, 20, 28 after the rise; enable dropped after cycle 30 suppresses 36.
    bus.rx_bps_en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      chk($sformatf("tick_c%0d", k), 32'(bus.clk_uart),
          32'((k == 4) || (k == 12) || (k == 20) || (k == 28)));
      if (k == 30) bus.rx_bps_en = 1'b0;
    end

    // Single frame with rx_done held 3 cycles.
    bus.irq_en  = 1'b1;
    bus.rx_data = 8'hA5;
    bus.rx_done = 1'b1;
    cyc(1);
    chk("frm_level",   32'(bus.level),   32'd1);
    chk("frm_rd_data", 32'(bus.rd_data), 32'hA5);
    chk("frm_empty",   32'(bus.empty),   32'd0);
    chk("frm_irq_lag", 32'(bus.irq),     32'd0);
    cyc(1);
    chk("frm_irq",     32'(bus.irq),     32'd1);
    cyc(1);
    bus.rx_done = 1'b0;
    chk("frm_one_push", 32'(bus.level),  32'd1);
    bus.rd_en = 1'b1;
    cyc(1);
    bus.rd_en = 1'b0;
    chk("frm_pop_empty", 32'(bus.empty), 32'd1);
    cyc(1);
    chk("frm_irq_clr",   32'(bus.irq),   32'd0);

    // Fill, overrun, drain, clear.
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    chk("fill_full",  32'(bus.full),  32'd1);
    chk("fill_level", 32'(bus.level), 32'd4);
    push_byte(8'h55);
    chk("ovr_set",    32'(bus.overrun), 32'd1);
    chk("ovr_level",  32'(bus.level),   32'd4);
    pop_chk("drain0", 8'h11);
    pop_chk("drain1", 8'h22);
    pop_chk("drain2", 8'h33);
    pop_chk("drain3", 8'h44);
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("ovr_sticky",  32'(bus.overrun), 32'd1);
    bus.clr_ovr = 1'b1;
    cyc(1);
    bus.clr_ovr = 1'b0;
    chk("ovr_clr", 32'(bus.overrun), 32'd0);

    // Push and pop together while full.
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    bus.rx_data = 8'h66;
    bus.rx_done = 1'b1;
    bus.rd_en   = 1'b1;
    cyc(1);
    bus.rx_done = 1'b0;
    bus.rd_en   = 1'b0;
    chk("pp_level",   32'(bus.level),   32'd4);
    chk("pp_full",    32'(bus.full),    32'd1);
    chk("pp_overrun", 32'(bus.overrun), 32'd0);
    cyc(1);
    pop_chk("pp0", 8'h22);
    pop_chk("pp1", 8'h33);
    pop_chk("pp2", 8'h44);
    pop_chk("pp3", 8'h66);

    // Reads while empty are ignored.
    bus.rd_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk($sformatf("uf_level%0d", k), 32'(bus.level), 32'd0);
      chk($sformatf("uf_empty%0d", k), 32'(bus.empty), 32'd1);
    end
    bus.rd_en = 1'b0;
    push_byte(8'h7E);
    chk("uf_rd_data", 32'(bus.rd_data), 32'h7E);
    chk("uf_level",   32'(bus.level),   32'd1);

    // Build level=2 with overrun set, then reset asynchronously while a tick is high.
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    push_byte(8'h04);
    chk("pre_ovr", 32'(bus.overrun), 32'd1);
    pop_chk("pre0", 8'h7E);
    pop_chk("pre1", 8'h01);
    chk("pre_level", 32'(bus.level), 32'd2);
    bus.rx_bps_en = 1'b1;
    cyc(4);
    chk("pre_tick", 32'(bus.clk_uart), 32'd1);
    chk("pre_irq",  32'(bus.irq),      32'd1);
    #2;
    RSTn = 1'b0;
    #1;
    chk("arst_clk_uart", 32'(bus.clk_uart), 32'd0);
    chk("arst_level",    32'(bus.level),    32'd0);
    chk("arst_empty",    32'(bus.empty),    32'd1);
    chk("arst_overrun",  32'(bus.overrun),  32'd0);
    chk("arst_irq",      32'(bus.irq),      32'd0);
    bus.rx_bps_en = 1'b0;
    cyc(1);
    RSTn = 1'b1;
    cyc(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
